// File: rtl/l3_field_extract.sv
// VLAN-aware L3 header locator and multi-field extractor for a valid/sop/eop word stream.
// Steps over stacked VLAN tags, classifies IPv4/IPv6 and captures configurable L3 bit-fields.
module l3_field_extract #(
  parameter int W                        = 32,
  parameter int NUM_FIELDS               = 2,
  parameter int FIELD_W                  = 16,
  parameter int FIELD_WORD [NUM_FIELDS]  = '{1, 2},
  parameter int FIELD_OFF  [NUM_FIELDS]  = '{0, 0},
  parameter int FIELD_LEN  [NUM_FIELDS]  = '{16, 16},
  parameter int ETYPE_WORD               = 3,
  parameter int ETYPE_LSB                = 0,
  parameter int MAX_VLAN_TAGS            = 2,
  parameter bit ENABLE_IPV6              = 1'b1,
  localparam int VW = (MAX_VLAN_TAGS > 0) ? $clog2(MAX_VLAN_TAGS + 1) : 1
) (
  input  logic                          sys_clk_i,
  input  logic                          reset_i,
  input  logic [W-1:0]                  in_data_i,
  input  logic                          in_valid_i,
  input  logic                          in_sop_i,
  input  logic                          in_eop_i,
  output logic                          l3_start_o,
  output logic                          l3_kind_o,
  output logic [VW-1:0]                 vlan_count_o,
  output logic [NUM_FIELDS*FIELD_W-1:0] fields_o,
  output logic                          fields_valid_o,
  output logic                          non_ip_o,
  output logic                          abort_o
);

  typedef enum logic [1:0] {IDLE, ETYPE, L3} state_e;

  function automatic int maxFieldWord();
    int m;
    m = 0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (FIELD_WORD[i] > m) m = FIELD_WORD[i];
    end
    return m;
  endfunction

  localparam int LAST_WORD = maxFieldWord();
  localparam int WCW       = $clog2(ETYPE_WORD + MAX_VLAN_TAGS + 2);

  state_e                          state_q, state_d;
  logic [WCW-1:0]                  wordCnt_q, wordCnt_d;
  logic [3:0]                      l3Cnt_q, l3Cnt_d;
  logic [VW-1:0]                   vlan_q, vlan_d;
  logic                            kind_q, kind_d;
  logic [NUM_FIELDS*FIELD_W-1:0]   fields_q, fields_d;
  logic                            l3Start_q, l3Start_d;
  logic                            fieldsValid_q, fieldsValid_d;
  logic                            nonIp_q, nonIp_d;
  logic                            abort_q, abort_d;
  logic [FIELD_W-1:0]              fieldCap [NUM_FIELDS];

  if (FIELD_W > W) begin : g_bad_width
    $error("FIELD_W must not exceed W");
  end

  for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_field
    if (FIELD_OFF[g] + FIELD_LEN[g] > W || FIELD_LEN[g] > FIELD_W ||
        FIELD_LEN[g] < 1 || FIELD_WORD[g] > 15) begin : g_bad_field
      $error("field geometry out of range");
    end
    assign fieldCap[g] = FIELD_W'(in_data_i[W-1-FIELD_OFF[g] -: FIELD_LEN[g]]);
  end

  // A sop word restarts the parse before the word itself is examined, so
  // the state/counter view used below is the post-restart one.
  always_comb begin
    state_e         st;
    logic [WCW-1:0] wc;
    logic [VW-1:0]  vc;
    logic [15:0]    etype;
    logic           isTag;
    logic           isIp;

    state_d       = state_q;
    wordCnt_d     = wordCnt_q;
    l3Cnt_d       = l3Cnt_q;
    vlan_d        = vlan_q;
    kind_d        = kind_q;
    fields_d      = fields_q;
    l3Start_d     = 1'b0;
    fieldsValid_d = 1'b0;
    nonIp_d       = 1'b0;
    abort_d       = 1'b0;

    st    = state_q;
    wc    = wordCnt_q;
    vc    = vlan_q;
    etype = in_data_i[ETYPE_LSB +: 16];
    isTag = (etype == 16'h8100) || (etype == 16'h88A8) || (etype == 16'h9100);
    isIp  = (etype == 16'h0800) || (ENABLE_IPV6 && (etype == 16'h86DD));

    if (in_valid_i) begin
      if (in_sop_i) begin
        abort_d = (state_q != IDLE);
        st      = ETYPE;
        wc      = '0;
        vc      = '0;
      end
      state_d = st;
      vlan_d  = vc;

      case (st)
        ETYPE: begin
          if (wc == WCW'(ETYPE_WORD) + WCW'(vc)) begin
            if (isTag) begin
              if (vc < VW'(MAX_VLAN_TAGS)) begin
                vlan_d = vc + VW'(1);
                if (in_eop_i) begin
                  abort_d = 1'b1;
                  state_d = IDLE;
                end
              end else begin
                abort_d = 1'b1;
                state_d = IDLE;
              end
            end else if (isIp) begin
              if (in_eop_i) begin
                abort_d = 1'b1;
                state_d = IDLE;
              end else begin
                l3Start_d = 1'b1;
                kind_d    = (etype == 16'h86DD);
                l3Cnt_d   = '0;
                state_d   = L3;
              end
            end else begin
              nonIp_d = 1'b1;
              state_d = IDLE;
            end
          end else if (in_eop_i) begin
            abort_d = 1'b1;
            state_d = IDLE;
          end
          wordCnt_d = (wc != '1) ? wc + WCW'(1) : wc;
        end

        L3: begin
          for (int i = 0; i < NUM_FIELDS; i++) begin
            if (l3Cnt_q == 4'(FIELD_WORD[i])) begin
              fields_d[i*FIELD_W +: FIELD_W] = fieldCap[i];
            end
          end
          if (l3Cnt_q == 4'(LAST_WORD)) begin
            fieldsValid_d = 1'b1;
            state_d       = IDLE;
          end else if (in_eop_i) begin
            abort_d = 1'b1;
            state_d = IDLE;
          end
          l3Cnt_d = (l3Cnt_q != 4'hF) ? l3Cnt_q + 4'd1 : l3Cnt_q;
        end

        default: ;
      endcase
    end
  end

  // All flags are registered, so every pulse lands one cycle after its deciding word.
  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      wordCnt_q     <= '0;
      l3Cnt_q       <= '0;
      vlan_q        <= '0;
      kind_q        <= 1'b0;
      fields_q      <= '0;
      l3Start_q     <= 1'b0;
      fieldsValid_q <= 1'b0;
      nonIp_q       <= 1'b0;
      abort_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      wordCnt_q     <= wordCnt_d;
      l3Cnt_q       <= l3Cnt_d;
      vlan_q        <= vlan_d;
      kind_q        <= kind_d;
      fields_q      <= fields_d;
      l3Start_q     <= l3Start_d;
      fieldsValid_q <= fieldsValid_d;
      nonIp_q       <= nonIp_d;
      abort_q       <= abort_d;
    end
  end

  assign l3_start_o     = l3Start_q;
  assign l3_kind_o      = kind_q;
  assign vlan_count_o   = vlan_q;
  assign fields_o       = fields_q;
  assign fields_valid_o = fieldsValid_q;
  assign non_ip_o       = nonIp_q;
  assign abort_o        = abort_q;

endmodule
